// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between decode and the execution channels / commit queue.
// The head entry issues with all-or-nothing acceptance and receives a gap-free commit ID.
module dispatch_queue #(
   parameter int NUM_UNITS = 5,
   parameter int PAYLOAD_W = 64,
   parameter int DEPTH     = 4,
   parameter int ID_W      = 8,
   parameter int UNIT_W    = $clog2(NUM_UNITS + 1)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         flash,
   input  logic                         in_en,
   input  logic [UNIT_W-1:0]            in_unit,
   input  logic [PAYLOAD_W-1:0]         in_payload,
   output logic                         in_reject,
   output logic [NUM_UNITS-1:0]         out_en,
   output logic [PAYLOAD_W-1:0]         out_payload,
   output logic [ID_W-1:0]              out_commit_id,
   input  logic [NUM_UNITS-1:0]         out_reject,
   output logic                         commit_en,
   output logic [UNIT_W-1:0]            commit_unit,
   input  logic                         commit_reject,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [UNIT_W-1:0] NUM_UNITS_U = UNIT_W'(NUM_UNITS);
   localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);

   logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
   logic [UNIT_W-1:0]    unit_mem    [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [ID_W-1:0]  commit_id;

   logic             valid;
   logic [UNIT_W-1:0] head_unit;
   logic             unit_rej;
   logic             side_ok;
   logic             push;
   logic             fire;

   assign valid     = (count != '0);
   assign head_unit = unit_mem[head];
   assign in_reject = (count == DEPTH_C);
   assign push      = in_en & ~in_reject & ~flash;

   // Commit-only heads never match a channel, so unit_rej stays 0 for them.
   always_comb begin
      unit_rej = 1'b0;
      out_en   = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (head_unit == UNIT_W'(u)) begin
            unit_rej  = out_reject[u];
            out_en[u] = valid & ~flash & ~commit_reject;
         end
      end
   end

   assign side_ok       = (head_unit >= NUM_UNITS_U) | ~unit_rej;
   assign commit_en     = valid & ~flash & side_ok;
   assign fire          = commit_en & ~commit_reject;
   assign out_payload   = payload_mem[head];
   assign commit_unit   = head_unit;
   assign out_commit_id = commit_id;

   // Storage is deliberately left unreset; contents are only observed while count != 0.
   always_ff @(posedge clock) begin
      if (push) begin
         payload_mem[tail] <= in_payload;
         unit_mem[tail]    <= in_unit;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (fire) head <= head + PTR_W'(1);
         case ({push, fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // IDs advance only on issue, so flushed entries never consume one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         commit_id <= '0;
      end else if (fire) begin
         commit_id <= commit_id + ID_W'(1);
      end
   end

endmodule
